// File: rtl/compress_pkg.sv
// Shared types and line geometry for the compression pipeline sequencer.
package compress_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLR   = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam int BEATS_PER_LINE = 8;
  localparam int WORDS_PER_BEAT = 2;

endpackage

// File: rtl/compress_pipe_ctrl_valid.sv
// Two-deep valid/last tag chain that shadows the Stage1/Stage2 data registers.
module comp_valid_pipe (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_flush,
  input  logic advance,
  input  logic issue,
  input  logic issue_last,
  output logic v1,
  output logic v2,
  output logic last1,
  output logic last2
);

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      v1    <= 1'b0;
      v2    <= 1'b0;
      last1 <= 1'b0;
      last2 <= 1'b0;
    end else if (i_flush) begin
      v1    <= 1'b0;
      v2    <= 1'b0;
      last1 <= 1'b0;
      last2 <= 1'b0;
    end else if (advance) begin
      v2    <= v1;
      last2 <= last1;
      v1    <= issue;
      last1 <= issue_last;
    end
  end

endmodule

// File: rtl/compress_pipe_ctrl.sv
// Line sequencer for the two-stage compression pipeline: accepts a cache line,
// issues its word-pair beats, and drives the global pipeline advance enable.
//
// state | meaning
// IDLE  | waiting for a line request
// CLR   | line accepted, dictionary cleared (one cycle)
// RUN   | issuing beats 0..BEATS-1 into Stage1
// DRAIN | waiting for the final beat to leave Stage2
module compress_pipe_ctrl
  import compress_pkg::*;
#(
  parameter  int BEATS  = BEATS_PER_LINE,
  localparam int BEAT_W = $clog2(BEATS)
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_req,
  input  logic              i_flush,
  input  logic              i_out_ready,
  output logic              o_ack,
  output logic              o_dict_clr,
  output logic [BEAT_W-1:0] o_word_sel,
  output logic              o_issue,
  output logic              o_pipe_en,
  output logic              o_s1_valid,
  output logic              o_s2_valid,
  output logic              o_s2_last,
  output logic              o_busy,
  output logic              o_line_done
);

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  state_t            state;
  logic [BEAT_W-1:0] cnt;
  logic              line_done;
  logic              advance;
  logic              issue;
  logic              issue_last;
  logic              v1, v2, last1, last2;

  assign advance    = i_out_ready | ~v2;
  assign issue      = (state == RUN) & advance;
  assign issue_last = issue & (cnt == LAST_BEAT);

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state     <= IDLE;
      cnt       <= '0;
      line_done <= 1'b0;
    end else if (i_flush) begin
      state     <= IDLE;
      cnt       <= '0;
      line_done <= 1'b0;
    end else begin
      line_done <= 1'b0;
      case (state)
        IDLE: if (i_req) state <= CLR;
        CLR: begin
          cnt   <= '0;
          state <= RUN;
        end
        RUN: begin
          if (advance) begin
            if (cnt == LAST_BEAT) begin
              cnt   <= '0;
              state <= DRAIN;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (advance && v2 && last2) begin
            state     <= IDLE;
            line_done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  comp_valid_pipe u_valid_pipe (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_flush    (i_flush),
    .advance    (advance),
    .issue      (issue),
    .issue_last (issue_last),
    .v1         (v1),
    .v2         (v2),
    .last1      (last1),
    .last2      (last2)
  );

  // Enable is forced low while reset is held so every output reads 0 immediately.
  assign o_pipe_en   = advance & i_reset;
  assign o_issue     = issue;
  assign o_word_sel  = cnt;
  assign o_ack       = (state == CLR);
  assign o_dict_clr  = (state == CLR);
  assign o_busy      = (state != IDLE);
  assign o_s1_valid  = v1;
  assign o_s2_valid  = v2;
  assign o_s2_last   = last2;
  assign o_line_done = line_done;

endmodule

// File: tb/tb_compress_pipe_ctrl.sv
// Directed bench for compress_pipe_ctrl with hand-derived per-cycle output vectors.
module tb_compress_pipe_ctrl;

  logic       i_clk = 1'b0;
  logic       i_reset;
  logic       i_req;
  logic       i_flush;
  logic       i_out_ready;
  logic       o_ack, o_dict_clr, o_issue, o_pipe_en;
  logic       o_s1_valid, o_s2_valid, o_s2_last, o_busy, o_line_done;
  logic [2:0] o_word_sel;

  int n_vec = 0;
  int n_err = 0;

  always #5 i_clk = ~i_clk;

  compress_pipe_ctrl dut (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_req       (i_req),
    .i_flush     (i_flush),
    .i_out_ready (i_out_ready),
    .o_ack       (o_ack),
    .o_dict_clr  (o_dict_clr),
    .o_word_sel  (o_word_sel),
    .o_issue     (o_issue),
    .o_pipe_en   (o_pipe_en),
    .o_s1_valid  (o_s1_valid),
    .o_s2_valid  (o_s2_valid),
    .o_s2_last   (o_s2_last),
    .o_busy      (o_busy),
    .o_line_done (o_line_done)
  );

  // {ack, dict_clr, word_sel[2:0], issue, pipe_en, s1_valid, s2_valid, s2_last, busy, line_done}
  function automatic logic [11:0] pack(input bit ack, input int ws, input bit iss,
                                       input bit pen, input bit s1, input bit s2,
                                       input bit s2l, input bit busy, input bit ld);
    logic [2:0] w;
    w = 3'(ws);
    return {ack, ack, w, iss, pen, s1, s2, s2l, busy, ld};
  endfunction

  // Unstalled line timing with i_req seen at edge 0 (BEATS = 8).
  function automatic logic [11:0] nom(input int c);
    return pack(c == 1, (c >= 2 && c <= 9) ? c - 2 : 0, c >= 2 && c <= 9, 1'b1,
                c >= 3 && c <= 10, c >= 4 && c <= 11, c == 11,
                c >= 1 && c <= 11, c == 12);
  endfunction

  task automatic edge_step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [11:0] exp);
    logic [11:0] obs;
    #2;
    obs = {o_ack, o_dict_clr, o_word_sel, o_issue, o_pipe_en,
           o_s1_valid, o_s2_valid, o_s2_last, o_busy, o_line_done};
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic run_line(input string tag);
    for (int c = 1; c <= 12; c++) begin
      edge_step();
      if (c == 1) i_req = 1'b0;
      chk($sformatf("%s_c%0d", tag, c), nom(c));
    end
  endtask

  initial begin
    i_reset     = 1'b0;
    i_req       = 1'b0;
    i_flush     = 1'b0;
    i_out_ready = 1'b1;

    chk("reset_t0", 12'h000);
    edge_step();
    chk("reset_hold", 12'h000);

    // Scenario 1: basic line
    i_reset = 1'b1;
    i_req   = 1'b1;
    chk("s1_c0", nom(0));
    run_line("s1");
    edge_step();
    chk("s1_idle", nom(0));

    // Scenario 2: three stall cycles
    edge_step();
    i_req = 1'b1;
    chk("s2_c0", nom(0));
    for (int c = 1; c <= 15; c++) begin
      logic [11:0] e;
      edge_step();
      if (c == 1) i_req = 1'b0;
      i_out_ready = !(c >= 5 && c <= 7);
      if (c < 5) e = nom(c);
      else if (c <= 7) e = pack(1'b0, 3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      else e = nom(c - 3);
      chk($sformatf("s2_c%0d", c), e);
    end
    i_out_ready = 1'b1;
    edge_step();
    chk("s2_idle", nom(0));

    // Scenario 3: back-to-back lines
    edge_step();
    i_req = 1'b1;
    chk("s3_c0", nom(0));
    for (int c = 1; c <= 24; c++) begin
      edge_step();
      if (c == 14) i_req = 1'b0;
      chk($sformatf("s3_c%0d", c), (c <= 12) ? nom(c) : nom(c - 12));
    end
    edge_step();
    chk("s3_idle", nom(0));

    // Scenario 4: flush mid-RUN
    edge_step();
    i_req = 1'b1;
    chk("s4_c0", nom(0));
    for (int c = 1; c <= 6; c++) begin
      edge_step();
      if (c == 1) i_req = 1'b0;
      if (c == 6) i_flush = 1'b1;
      chk($sformatf("s4_c%0d", c), nom(c));
    end
    for (int c = 7; c <= 9; c++) begin
      edge_step();
      i_flush = 1'b0;
      chk($sformatf("s4_post_c%0d", c), nom(0));
    end
    edge_step();
    i_req = 1'b1;
    chk("s4_restart_c0", nom(0));
    run_line("s4_restart");

    // Scenario 5: async reset in DRAIN
    edge_step();
    i_req = 1'b1;
    chk("s5_c0", nom(0));
    for (int c = 1; c <= 10; c++) begin
      edge_step();
      if (c == 1) i_req = 1'b0;
      chk($sformatf("s5_c%0d", c), nom(c));
    end
    #1 i_reset = 1'b0;
    i_req = 1'b1;
    #1;
    n_vec++;
    assert ({o_ack, o_dict_clr, o_word_sel, o_issue, o_pipe_en, o_s1_valid,
             o_s2_valid, o_s2_last, o_busy, o_line_done} === 12'h000)
    else begin
      n_err++;
      $error("FAIL s5_async: observed %b%b%h%b%b%b%b%b%b%b expected all zero",
             o_ack, o_dict_clr, o_word_sel, o_issue, o_pipe_en, o_s1_valid,
             o_s2_valid, o_s2_last, o_busy, o_line_done);
    end
    edge_step();
    chk("s5_rst_hold1", 12'h000);
    edge_step();
    chk("s5_rst_hold2", 12'h000);
    i_reset = 1'b1;
    chk("s5_rel_c0", nom(0));
    run_line("s5_rel");

    // Scenario 6: request and flush together in IDLE
    edge_step();
    i_req   = 1'b1;
    i_flush = 1'b1;
    chk("s6_both", nom(0));
    edge_step();
    i_flush = 1'b0;
    chk("s6_after_flush", nom(0));
    run_line("s6");
    edge_step();
    chk("s6_idle", nom(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/compress_pipe_ctrl.md
Name: compress_pipe_ctrl

Overview:
Sequencer for the two-stage compression pipeline (Stage1 match-type generation, Stage2 length/packing).
- Accepts one cache line per request and steps its word pairs through the pipeline, one beat per cycle.
- Drives a single global advance enable for the Stage1/Stage2 pipeline registers, including the match-type/length register.
- Tracks per-stage valid and last tags, stalls on packer backpressure, and clears the dictionary at each line start.

Parameters:
BEATS, 8, word-pair beats per line (16 x 32-bit words, two words per beat); must be >= 2.
BEAT_W, $clog2(BEATS), beat index width; derived, not overridden.

Ports:
i_clk  input  1  clock; all state updates on posedge.
i_reset  input  1  asynchronous, active-low reset.
i_req  input  1  line available; sampled only in IDLE; held until o_ack.
i_flush  input  1  synchronous abort; highest priority after reset.
i_out_ready  input  1  packer can accept the Stage2 beat this cycle.
o_ack  output  1  one-cycle line-accepted pulse.
o_dict_clr  output  1  one-cycle dictionary clear, coincident with o_ack.
o_word_sel  output  BEAT_W  index of the word pair issued into Stage1 this cycle.
o_issue  output  1  a new beat enters Stage1 at this edge.
o_pipe_en  output  1  global advance enable for Stage1/Stage2 pipeline registers.
o_s1_valid  output  1  Stage1 register holds a valid beat.
o_s2_valid  output  1  Stage2 register holds a valid beat (to packer).
o_s2_last  output  1  Stage2 beat is the line's final beat.
o_busy  output  1  state != IDLE.
o_line_done  output  1  one-cycle pulse after the final beat is consumed.

Behaviour:
- FSM states: IDLE, CLR, RUN, DRAIN.
- Reset (async, i_reset=0) forces:
  - state=IDLE, beat counter=0, v1=v2=last1=last2=0.
  - All outputs 0, including o_word_sel=0.
- Advance rule: advance = i_out_ready | ~v2. o_pipe_en = advance in every state, including IDLE, so bubbles drain.
- On an advance edge:
  - v2<=v1, last2<=last1.
  - v1<=o_issue, last1<=(o_issue & cnt==BEATS-1).
- Without advance, v1, v2, last1, last2 and cnt all hold.
- IDLE: o_busy=0. If i_req=1 at an edge, go to CLR.
- CLR (exactly 1 cycle): o_ack=1, o_dict_clr=1, cnt<=0, then go to RUN. No issue occurs in CLR.
- RUN:
  - o_issue = advance; o_word_sel = cnt.
  - On issue: cnt<=cnt+1. When issuing cnt==BEATS-1, go to DRAIN with cnt<=0 (no wrap past BEATS-1).
  - Stall (advance=0): o_issue=0; cnt and o_word_sel hold.
- DRAIN:
  - No issue.
  - When an advance edge occurs with v2=1 and last2=1, go to IDLE and register o_line_done=1 for the next cycle.
- o_s1_valid=v1, o_s2_valid=v2, o_s2_last=last2 (all registered).
- i_flush=1 at an edge:
  - state<=IDLE, cnt<=0, v1=v2=last1=last2<=0.
  - o_line_done is not produced.
  - Flush wins over a simultaneous i_req, a final-beat consume, or a line_done pending in the same cycle.
- New request in the same cycle as line_done: the FSM is already in IDLE, so i_req is accepted, giving back-to-back lines with no extra bubble.
- i_req is ignored outside IDLE.
- Latency, no stalls, i_req seen at edge 0:
  - CLR in cycle 1.
  - Beats 0..BEATS-1 issued in cycles 2..BEATS+1.
  - s2 holds the last beat in cycle BEATS+3.
  - o_line_done in cycle BEATS+4 (cycle 12 for BEATS=8).
- Each stall cycle (v2=1, i_out_ready=0) adds exactly one cycle to the total.

Decomposition:
- Shared package compress_pkg holds:
  - State enum typedef: IDLE, CLR, RUN, DRAIN.
  - BEATS_PER_LINE = 8 and WORDS_PER_BEAT = 2.
- One natural sub-module: comp_valid_pipe, the two-deep valid/last shift chain with hold on ~advance and clear on flush/reset.
- The FSM and beat counter stay in the top module.

Test Plan:
1. Reset then i_req=1 at cycle 0, i_out_ready=1 constant -> o_ack and o_dict_clr high in cycle 1 only; o_word_sel=0..7 with o_issue in cycles 2..9; o_s2_valid cycles 4..11; o_s2_last only in cycle 11; o_line_done in cycle 12; o_busy cycles 1..11.
2. Same as 1 but i_out_ready=0 during cycles 5..7 -> o_pipe_en=0 and o_word_sel holds at 3 for those 3 cycles; no beat lost or duplicated; o_line_done moves to cycle 15.
3. i_req held high continuously -> second o_ack in cycle 13 (the cycle after the first line's o_line_done in cycle 12); beat indices restart at 0; 8 beats per line.
4. i_flush=1 in cycle 6 mid-RUN -> cycle 7: o_busy=0, o_s1_valid=o_s2_valid=0; no o_line_done; next i_req starts cleanly from beat 0 with a fresh o_dict_clr.
5. Async reset asserted mid-DRAIN (no clock edge) -> all outputs 0 immediately; i_req ignored until i_reset=1; after release, scenario 1 timing repeats exactly.
6. i_req and i_flush both high in IDLE -> no o_ack; the FSM stays IDLE; the request is accepted on the next edge after i_flush drops.
